// File: rtl/inst_fetch_queue_if.sv
// ============================================================================
// inst_fetch_queue_if : instruction-cache request and decoder handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface inst_fetch_queue_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_valid;
  logic [31:0] icache_inst;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;

  modport master (
    output icache_req, icache_addr, dec_valid, dec_inst, dec_pc,
    input  icache_valid, icache_inst, dec_ready
  );

  modport slave (
    input  icache_req, icache_addr, dec_valid, dec_inst, dec_pc,
    output icache_valid, icache_inst, dec_ready
  );
endinterface

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// inst_fetch_queue : PC sequencer, single-outstanding icache fetch, circular
//                    instruction FIFO feeding the decoder, ROB flush redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module inst_fetch_queue #(
  parameter int          QUEUE_WIDTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      clear,
  input  logic [31:0]               clear_pc,
  inst_fetch_queue_if.master        bus
);

  localparam int                   DEPTH   = 2 ** QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] DEPTH_C = (QUEUE_WIDTH + 1)'(DEPTH);
  localparam logic [QUEUE_WIDTH:0] CNT_ONE = (QUEUE_WIDTH + 1)'(1);
  localparam logic [QUEUE_WIDTH-1:0] PTR_ONE = QUEUE_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [QUEUE_WIDTH-1:0] head_q, head_d;
  logic [QUEUE_WIDTH-1:0] tail_q, tail_d;
  logic [QUEUE_WIDTH:0]   count_q, count_d;
  logic                   req_q, req_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            mem_pc_q   [DEPTH];
  logic [31:0]            mem_pc_d   [DEPTH];
  logic [31:0]            mem_inst_q [DEPTH];
  logic [31:0]            mem_inst_d [DEPTH];
  logic                   push;
  logic                   pop;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    req_d      = req_q;
    addr_d     = addr_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    push       = 1'b0;
    pop        = 1'b0;

    if (rdy_in) begin
      if (clear) begin
        // Flush wins over everything; an in-flight request is left to drain in DROP.
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
        pc_d    = clear_pc;
        case (state_q)
          S_WAIT, S_DROP: begin
            if (bus.icache_valid) begin
              req_d   = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_DROP;
            end
          end
          default: ;
        endcase
      end else begin
        pop = (count_q != '0) && bus.dec_ready;
        case (state_q)
          S_IDLE: begin
            // Issuing only below DEPTH reserves the slot the response will land in.
            if (count_q != DEPTH_C) begin
              req_d   = 1'b1;
              addr_d  = pc_q;
              state_d = S_WAIT;
            end
          end
          S_WAIT: begin
            if (bus.icache_valid) begin
              push    = 1'b1;
              pc_d    = pc_q + 32'd4;
              req_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
          S_DROP: begin
            if (bus.icache_valid) begin
              req_d   = 1'b0;
              state_d = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase

        if (push) begin
          mem_pc_d[tail_q]   = pc_q;
          mem_inst_d[tail_q] = bus.icache_inst;
          tail_d             = tail_q + PTR_ONE;
        end
        if (pop) begin
          head_d = head_q + PTR_ONE;
        end
        case ({push, pop})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      mem_pc_q   <= mem_pc_d;
      mem_inst_q <= mem_inst_d;
    end
  end

  assign bus.icache_req  = req_q;
  assign bus.icache_addr = addr_q;
  assign bus.dec_valid   = (count_q != '0);
  assign bus.dec_inst    = mem_inst_q[head_q];
  assign bus.dec_pc      = mem_pc_q[head_q];

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
// ============================================================================
// tb_inst_fetch_queue : scoreboard bench with a latency-programmable icache
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_queue;

  localparam int DEPTH = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        clr;
  logic [31:0] clr_pc;

  inst_fetch_queue_if bus();

  inst_fetch_queue #(.QUEUE_WIDTH(4), .RESET_PC(32'h0)) dut (
    .clk_in   (clk),
    .rst_in   (rst_n),
    .rdy_in   (rdy),
    .clear    (clr),
    .clear_pc (clr_pc),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  ent_t        q[$];
  logic [31:0] exp_pc;
  bit          outstanding, dropped;
  int          cnt, lat, req_count;
  logic [31:0] out_addr;
  bit          t_rdy, t_clear, t_dec_ready, ready_on_resp, clear_on_resp;
  logic [31:0] t_clear_pc, cor_pc;
  bit          last_rdy;
  logic        s_req, s_dv;
  logic [31:0] s_addr, s_pc, s_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc      = 32'h0;
    outstanding = 1'b0;
    dropped     = 1'b0;
    cnt         = 0;
    last_rdy    = 1'b1;
  endtask

  // One clock: check what the last edge produced, drive this cycle, predict the next edge.
  task automatic tick();
    ent_t e;
    @(negedge clk);
    check("dec_valid", 32'(bus.dec_valid), 32'(q.size() != 0));
    if (!last_rdy) begin
      check("hold_req",  32'(bus.icache_req), 32'(s_req));
      check("hold_addr", bus.icache_addr, s_addr);
      check("hold_dv",   32'(bus.dec_valid), 32'(s_dv));
      check("hold_pc",   bus.dec_pc, s_pc);
      check("hold_inst", bus.dec_inst, s_inst);
    end
    if (q.size() == DEPTH && !outstanding)
      check("full_noreq", 32'(bus.icache_req), 32'h0);
    if (outstanding) begin
      check("req_held",  32'(bus.icache_req), 32'h1);
      check("addr_held", bus.icache_addr, out_addr);
    end else if (bus.icache_req) begin
      outstanding = 1'b1;
      cnt         = 0;
      out_addr    = bus.icache_addr;
      req_count++;
      check("req_addr", bus.icache_addr, exp_pc);
    end

    rdy              = t_rdy;
    clr              = t_clear;
    clr_pc           = t_clear_pc;
    bus.icache_valid = 1'b0;
    if (t_rdy && outstanding) begin
      cnt++;
      if (cnt >= lat) begin
        bus.icache_valid = 1'b1;
        bus.icache_inst  = inst_of(out_addr);
      end
    end
    if (bus.icache_valid && clear_on_resp) begin
      clr           = 1'b1;
      clr_pc        = cor_pc;
      clear_on_resp = 1'b0;
    end
    bus.dec_ready = ready_on_resp ? bus.icache_valid : t_dec_ready;

    if (t_rdy) begin
      if (bus.dec_valid && bus.dec_ready && !clr && q.size() != 0) begin
        e = q.pop_front();
        check("dec_pc",   bus.dec_pc, e.pc);
        check("dec_inst", bus.dec_inst, e.inst);
      end
      if (bus.icache_valid) begin
        outstanding = 1'b0;
        if (!clr && !dropped) begin
          q.push_back('{pc: exp_pc, inst: inst_of(exp_pc)});
          exp_pc = exp_pc + 32'd4;
        end
        dropped = 1'b0;
      end
      if (clr) begin
        q.delete();
        exp_pc = clr_pc;
        if (outstanding) dropped = 1'b1;
      end
    end

    s_req    = bus.icache_req;
    s_addr   = bus.icache_addr;
    s_dv     = bus.dec_valid;
    s_pc     = bus.dec_pc;
    s_inst   = bus.dec_inst;
    last_rdy = t_rdy;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_clear(input logic [31:0] pc);
    t_clear    = 1'b1;
    t_clear_pc = pc;
    tick();
    t_clear    = 1'b0;
  endtask

  task automatic wait_size(input int n, input int budget);
    int i = 0;
    while (q.size() != n && i < budget) begin
      tick();
      i++;
    end
    check("wait_size", q.size(), n);
  endtask

  task automatic wait_fresh_req(input int budget);
    int i = 0;
    while (!(outstanding && cnt == 1) && i < budget) begin
      tick();
      i++;
    end
    check("wait_req", 32'(outstanding && cnt == 1), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst_n = 1'b1;
    rdy = 1'b0; clr = 1'b0; clr_pc = '0;
    bus.icache_valid = 1'b0; bus.icache_inst = '0; bus.dec_ready = 1'b0;
    t_rdy = 1'b1; t_clear = 1'b0; t_clear_pc = '0; t_dec_ready = 1'b1;
    ready_on_resp = 1'b0; clear_on_resp = 1'b0; cor_pc = '0;
    lat = 1; req_count = 0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req",  32'(bus.icache_req), 32'h0);
    check("rst_addr", bus.icache_addr, 32'h0);
    check("rst_dv",   32'(bus.dec_valid), 32'h0);
    check("rst_inst", bus.dec_inst, 32'h0);
    check("rst_pc",   bus.dec_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming with a one-cycle cache and an always-ready decoder
    run(40);

    // fill to DEPTH, then a single pop must trigger exactly one refill request
    t_dec_ready = 1'b0;
    wait_size(DEPTH, 200);
    run(8);
    r0 = req_count;
    t_dec_ready = 1'b1;
    tick();
    t_dec_ready = 1'b0;
    run(10);
    check("one_refill", req_count - r0, 32'd1);
    check("refull", q.size(), DEPTH);

    // near-full: every response coincides with a pop
    t_dec_ready = 1'b1;
    tick();
    t_dec_ready = 1'b0;
    r0 = req_count;
    ready_on_resp = 1'b1;
    run(16);
    ready_on_resp = 1'b0;
    check("pushpop_reqs", 32'(req_count - r0 >= 5), 32'h1);
    t_dec_ready = 1'b1;
    run(40);

    // flush while waiting on a slow cache
    lat = 3;
    wait_fresh_req(50);
    pulse_clear(32'h100);
    check("flush_dv", 32'(bus.dec_valid), 32'h0);
    run(30);

    // flush coinciding with the response
    lat = 2;
    cor_pc = 32'h200;
    clear_on_resp = 1'b1;
    run(30);
    check("cor_used", 32'(clear_on_resp), 32'h0);

    // freeze with a valid head and a ready decoder
    t_dec_ready = 1'b0;
    run(8);
    t_dec_ready = 1'b1;
    t_rdy = 1'b0;
    tick();
    check("frz_valid", 32'(bus.dec_valid), 32'h1);
    run(5);
    t_rdy = 1'b1;
    run(30);

    // address wrap past 2^32
    lat = 1;
    pulse_clear(32'hFFFF_FFF8);
    run(20);

    // asynchronous reset while a request is outstanding
    lat = 4;
    t_dec_ready = 1'b0;
    run(20);
    wait_fresh_req(50);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req",  32'(bus.icache_req), 32'h0);
    check("arst_addr", bus.icache_addr, 32'h0);
    check("arst_dv",   32'(bus.dec_valid), 32'h0);
    check("arst_inst", bus.dec_inst, 32'h0);
    check("arst_pc",   bus.dec_pc, 32'h0);
    bus.icache_valid = 1'b0;
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 1;
    t_dec_ready = 1'b1;
    run(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
